prbs7_checker: RTL and testbench

- Receive-side counterpart of the team's 7-bit LFSR pattern generator (x^7 + x^3 + 1, shift-left, new LSB = s[6] ^ s[2]).
- Takes the generated pattern as a serial bit stream, self-synchronises to it and declares lock.
- Once locked, flywheels a local copy of the sequence and counts bit errors; drops lock after too many errors in a window.
- Used on the bench and in-system to check that generator, serialiser and link are intact.

---
 rtl/prbs7_checker.sv | 136 +++++++++++++
 tb/tb_prbs7_checker.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs7_checker.sv
// Serial checker for the x^7 + x^3 + 1 pattern: self-synchronises, locks, then
// flywheels the local sequence and counts received bit errors.
//
// state  | meaning
// HUNT   | filling history with received bits, waiting for a non-zero seed
// VERIFY | seeded from the line, counting consecutive correct predictions
// LOCKED | flywheeling own sequence, counting errors, windowed loss-of-lock
module prbs7_checker #(
    parameter int LOCK_COUNT = 16,
    parameter int ERR_WINDOW = 127,
    parameter int ERR_THRESH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 bit_in,
    input  logic                 clr_count,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
    localparam int EW = $clog2(ERR_THRESH + 1);

    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(ERR_WINDOW - 1);
    localparam logic [EW-1:0] THRESH     = EW'(ERR_THRESH);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t         state;
    logic [6:0]     hist;
    logic [2:0]     fill;
    logic [MW-1:0]  match_cnt;
    logic [WW-1:0]  win_left;
    logic [EW-1:0]  win_err;

    logic           pred;
    logic           mismatch;
    logic [6:0]     hist_rx;
    logic [6:0]     hist_fly;
    logic [EW-1:0]  win_err_nx;
    logic           err_inc;

    assign pred     = hist[6] ^ hist[2];
    assign mismatch = bit_in ^ pred;
    assign hist_rx  = {hist[5:0], bit_in};
    assign hist_fly = {hist[5:0], pred};
    assign locked   = (state == LOCKED);
    assign err_inc  = en && (state == LOCKED) && mismatch;

    // The window timer counts down; an error on the terminal bit opens the new window.
    always_comb begin
        win_err_nx = win_err + EW'(mismatch);
        if (win_left == '0) begin
            win_err_nx = mismatch ? EW'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            win_left  <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (en) begin
                case (state)
                    HUNT: begin
                        hist <= hist_rx;
                        if (fill != 3'd7) begin
                            fill <= fill + 3'd1;
                        end
                        if ((fill >= 3'd6) && (hist_rx != '0)) begin
                            state     <= VERIFY;
                            match_cnt <= '0;
                        end
                    end
                    VERIFY: begin
                        hist <= hist_rx;
                        if (hist_rx == '0) begin
                            state <= HUNT;
                            fill  <= '0;
                        end else if (mismatch) begin
                            match_cnt <= '0;
                        end else if (match_cnt == MATCH_LAST) begin
                            state    <= LOCKED;
                            win_left <= WIN_LAST;
                            win_err  <= '0;
                        end else begin
                            match_cnt <= match_cnt + MW'(1);
                        end
                    end
                    LOCKED: begin
                        // Flywheel: shifting in the prediction stops one bad bit
                        // from poisoning the following predictions.
                        hist      <= hist_fly;
                        err_pulse <= mismatch;
                        win_err   <= win_err_nx;
                        win_left  <= (win_left == '0) ? WIN_LAST : win_left - WW'(1);
                        if (win_err_nx == THRESH) begin
                            state <= HUNT;
                            fill  <= '0;
                        end
                    end
                    default: begin
                        state <= HUNT;
                        fill  <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (clr_count) begin
            err_count <= '0;
        end else if (err_inc && (err_count != '1)) begin
            err_count <= err_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: scenario tasks plus randomized traffic, all checked
// against a queue-based model of the lock/flywheel/window rules.
module tb_prbs7_checker;

    localparam int LOCK_COUNT = 16;
    localparam int ERR_WINDOW = 127;
    localparam int ERR_THRESH = 8;
    localparam int CNT_WIDTH  = 16;
    localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic bit_in = 1'b0;
    logic clr_count = 1'b0;
    logic locked;
    logic err_pulse;
    logic [CNT_WIDTH-1:0] err_count;

    prbs7_checker #(
        .LOCK_COUNT(LOCK_COUNT),
        .ERR_WINDOW(ERR_WINDOW),
        .ERR_THRESH(ERR_THRESH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .bit_in   (bit_in),
        .clr_count(clr_count),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // full[0..6] are the seed bits oldest first; stream bit n is full[7 + n%127]
    bit full [0:133];

    // model: 0 = hunting, 1 = verifying, 2 = locked
    int m_state;
    bit m_hist[$];
    int m_fill, m_match, m_wbits, m_werr, m_cnt;
    bit m_pulse;

    function automatic bit gen_bit(int n);
        return full[7 + (n % 127)];
    endfunction

    function automatic bit hist_zero();
        foreach (m_hist[i]) if (m_hist[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(bit r, bit e, bit b, bit c);
        bit pred, err;
        if (r) begin
            m_state = 0; m_fill = 0; m_match = 0; m_wbits = 0; m_werr = 0;
            m_cnt = 0; m_pulse = 0;
            m_hist.delete();
            repeat (7) m_hist.push_back(1'b0);
            return;
        end
        err = 0;
        m_pulse = 0;
        if (e) begin
            pred = m_hist[0] ^ m_hist[4];   // b[n-7] ^ b[n-3]
            void'(m_hist.pop_front());
            if (m_state == 0) begin
                m_hist.push_back(b);
                if (m_fill < 7) m_fill++;
                if (m_fill == 7 && !hist_zero()) begin m_state = 1; m_match = 0; end
            end else if (m_state == 1) begin
                m_hist.push_back(b);
                if (hist_zero()) begin m_state = 0; m_fill = 0; end
                else if (b != pred) m_match = 0;
                else begin
                    m_match++;
                    if (m_match == LOCK_COUNT) begin m_state = 2; m_wbits = 0; m_werr = 0; end
                end
            end else begin
                m_hist.push_back(pred);
                err = (b != pred);
                m_pulse = err;
                if (m_wbits == ERR_WINDOW - 1) begin m_wbits = 0; m_werr = err; end
                else begin m_wbits++; m_werr += err; end
                if (m_werr == ERR_THRESH) begin m_state = 0; m_fill = 0; end
            end
        end
        if (c) m_cnt = 0;
        else if (err && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic cyc(bit r, bit e, bit b, bit c);
        @(negedge clk);
        rst = r; en = e; bit_in = b; clr_count = c;
        @(posedge clk);
        model_step(r, e, b, c);
        #1;
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 0);
    endtask

    task automatic test_reset();
        cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 0);
        checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got locked=%b pulse=%b, want 0 0", locked, err_pulse);
        end
        checks++;
        if (err_count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d, want 0", err_count);
        end
    endtask

    task automatic test_lock_clean();
        int first_lock = -1;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            cyc(0, 1, gen_bit(n), 0);
            checks++;
            if (locked !== 1'(m_state == 2) || err_pulse !== m_pulse || err_count !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL lock_clean bit %0d: got %b %b %0d, want %b %b %0d", n,
                         locked, err_pulse, err_count, m_state == 2, m_pulse, m_cnt);
            end
            if (locked && first_lock < 0) first_lock = n + 1;
        end
        checks++;
        if (first_lock != 23) begin
            errors++;
            $display("FAIL lock_latency: got %0d bits, want 23", first_lock);
        end
        checks++;
        if (err_count !== '0) begin
            errors++;
            $display("FAIL clean_count: got %0d, want 0", err_count);
        end
    endtask

    task automatic test_single_error();
        int pulses = 0;
        do_reset();
        for (int n = 0; n < 200; n++) begin
            cyc(0, 1, gen_bit(n) ^ (n == 60), 0);
            checks++;
            if (locked !== 1'(m_state == 2) || err_pulse !== m_pulse || err_count !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL single_err bit %0d: got %b %b %0d, want %b %b %0d", n,
                         locked, err_pulse, err_count, m_state == 2, m_pulse, m_cnt);
            end
            if (err_pulse) pulses++;
        end
        checks++;
        if (pulses != 1 || err_count !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL single_err_total: got pulses=%0d cnt=%0d locked=%b, want 1 1 1",
                     pulses, err_count, locked);
        end
    endtask

    task automatic test_burst_unlock();
        int lost = -1;
        int k = 0;
        bit b;
        do_reset();
        for (int n = 0; n < 86; n++) begin
            b = gen_bit(n) ^ (n >= 50 && (n - 50) % 5 == 0);
            cyc(0, 1, b, 0);
            checks++;
            if (locked !== 1'(m_state == 2) || err_pulse !== m_pulse || err_count !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL burst bit %0d: got %b %b %0d, want %b %b %0d", n,
                         locked, err_pulse, err_count, m_state == 2, m_pulse, m_cnt);
            end
            if (n >= 23 && !locked && lost < 0) lost = n;
        end
        checks++;
        if (lost != 85 || err_count !== 16'd8) begin
            errors++;
            $display("FAIL burst_unlock: got lost at %0d cnt=%0d, want 85 8", lost, err_count);
        end
        for (int n = 86; n < 186; n++) begin
            cyc(0, 1, gen_bit(n), 0);
            k++;
            if (locked) break;
        end
        checks++;
        if (k != 23 || locked !== 1'b1 || err_count !== 16'd8) begin
            errors++;
            $display("FAIL burst_relock: got %0d bits locked=%b cnt=%0d, want 23 1 8",
                     k, locked, err_count);
        end
    endtask

    task automatic test_window_split();
        bit dropped = 0;
        bit b;
        do_reset();
        for (int n = 0; n < 200; n++) begin
            b = gen_bit(n) ^ ((n >= 30 && n <= 90 && n % 10 == 0) || n == 160);
            cyc(0, 1, b, 0);
            checks++;
            if (locked !== 1'(m_state == 2) || err_pulse !== m_pulse || err_count !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL window bit %0d: got %b %b %0d, want %b %b %0d", n,
                         locked, err_pulse, err_count, m_state == 2, m_pulse, m_cnt);
            end
            if (n >= 22 && !locked) dropped = 1;
        end
        checks++;
        if (dropped || err_count !== 16'd8) begin
            errors++;
            $display("FAIL window_split: got dropped=%b cnt=%0d, want 0 8", dropped, err_count);
        end
    endtask

    task automatic test_zero_stream();
        bit ever = 0;
        do_reset();
        for (int n = 0; n < 200; n++) begin
            cyc(0, 1, 0, 0);
            if (locked) ever = 1;
        end
        checks++;
        if (ever || err_count !== '0) begin
            errors++;
            $display("FAIL zero_stream: got ever_locked=%b cnt=%0d, want 0 0", ever, err_count);
        end
    endtask

    task automatic test_random_en();
        int pos = 0;
        int lock_at = -1;
        bit e, b;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            e = 1'($urandom_range(0, 1));
            b = e ? gen_bit(pos) : 1'($urandom_range(0, 1));
            cyc(0, e, b, 0);
            if (e) pos++;
            checks++;
            if (locked !== 1'(m_state == 2) || err_pulse !== m_pulse || err_count !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL random_en cyc %0d: got %b %b %0d, want %b %b %0d", i,
                         locked, err_pulse, err_count, m_state == 2, m_pulse, m_cnt);
            end
            if (locked && lock_at < 0) lock_at = pos;
        end
        checks++;
        if (lock_at != 23 || err_count !== '0) begin
            errors++;
            $display("FAIL random_en_lock: got lock at %0d cnt=%0d, want 23 0", lock_at, err_count);
        end
    endtask

    task automatic test_clr_same_edge();
        do_reset();
        for (int n = 0; n < 56; n++)
            cyc(0, 1, gen_bit(n) ^ (n == 45 || n == 50 || n == 55), n == 55);
        checks++;
        if (err_count !== '0 || err_pulse !== 1'b1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL clr_same_edge: got cnt=%0d pulse=%b locked=%b, want 0 1 1",
                     err_count, err_pulse, locked);
        end
        cyc(0, 1, gen_bit(56) ^ 1'b1, 0);
        cyc(0, 0, 0, 1);
        checks++;
        if (err_count !== '0 || err_pulse !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL clr_no_en: got cnt=%0d pulse=%b locked=%b, want 0 0 1",
                     err_count, err_pulse, locked);
        end
    endtask

    task automatic test_rst_locked();
        int k = 0;
        do_reset();
        for (int n = 0; n < 40; n++) cyc(0, 1, gen_bit(n) ^ (n == 35), 0);
        cyc(1, 1, gen_bit(40), 0);
        checks++;
        if (locked !== 1'b0 || err_count !== '0) begin
            errors++;
            $display("FAIL rst_locked: got locked=%b cnt=%0d, want 0 0", locked, err_count);
        end
        for (int n = 41; n < 141; n++) begin
            cyc(0, 1, gen_bit(n), 0);
            k++;
            if (locked) break;
        end
        checks++;
        if (k != 23) begin
            errors++;
            $display("FAIL rst_relock: got %0d bits, want 23", k);
        end
    endtask

    task automatic test_random_traffic();
        int pos = 0;
        bit r, e, b, c;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 999) == 0);
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 63) == 0);
            b = e ? gen_bit(pos) ^ ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
            cyc(r, e, b, c);
            if (e) pos++;
            checks++;
            if (locked !== 1'(m_state == 2) || err_pulse !== m_pulse || err_count !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL random cyc %0d: got %b %b %0d, want %b %b %0d", i,
                         locked, err_pulse, err_count, m_state == 2, m_pulse, m_cnt);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 7; i++) full[i] = (i == 6);
        for (int i = 7; i < 134; i++) full[i] = full[i-7] ^ full[i-3];
        test_reset();
        test_lock_clean();
        test_single_error();
        test_burst_unlock();
        test_window_split();
        test_zero_stream();
        test_random_en();
        test_clr_same_edge();
        test_rst_locked();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
